// File: rtl/ehgu_sync_fifo_ctrl.sv
// FIFO controller for an external dual-port memory: pointers, level count, flags,
// sticky errors, synchronous flush and a read-data-valid pipeline.
module ehgu_sync_fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 128,
  parameter int AWIDTH    = 8,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  output logic              wenable,
  output logic [AWIDTH-1:0] waddr,
  output logic              renable,
  output logic [AWIDTH-1:0] raddr,
  output logic              rvalid,
  output logic [AWIDTH:0]   count,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AWIDTH:0]   L_DEPTH  = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0]   L_AFULL  = (AWIDTH + 1)'(AFULL_TH);
  localparam logic [AWIDTH:0]   L_AEMPTY = (AWIDTH + 1)'(AEMPTY_TH);
  localparam logic [AWIDTH-1:0] L_LAST   = AWIDTH'(DEPTH - 1);

  // WIDTH only describes the attached memory; nothing here depends on it.
  if (WIDTH < 1) begin : g_width_guard
  end

  logic [AWIDTH-1:0] r_waddr;
  logic [AWIDTH-1:0] r_raddr;
  logic [AWIDTH:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_afull;
  logic              r_aempty;
  logic              r_ovf;
  logic              r_udf;
  logic [RD_LAT-1:0] r_rv_pipe;

  logic              w_wen;
  logic              w_ren;
  logic              w_ovf_ev;
  logic              w_udf_ev;
  logic [AWIDTH:0]   w_count_next;

  // rstn gating keeps the enables quiet while reset is held.
  assign w_wen    = rstn & en & push & ~r_full  & ~flush;
  assign w_ren    = rstn & en & pop  & ~r_empty & ~flush;
  assign w_ovf_ev = en & push & r_full  & ~flush;
  assign w_udf_ev = en & pop  & r_empty & ~flush;

  always_comb begin
    w_count_next = r_count;
    if (w_wen && !w_ren) begin
      w_count_next = r_count + 1'b1;
    end else if (w_ren && !w_wen) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_rv_pipe <= '0;
    end else if (flush) begin
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_rv_pipe <= '0;
    end else begin
      // Explicit wrap so non-power-of-two depths work without modulo.
      if (w_wen) begin
        r_waddr <= (r_waddr == L_LAST) ? '0 : r_waddr + 1'b1;
      end
      if (w_ren) begin
        r_raddr <= (r_raddr == L_LAST) ? '0 : r_raddr + 1'b1;
      end
      r_count  <= w_count_next;
      r_full   <= (w_count_next == L_DEPTH);
      r_empty  <= (w_count_next == '0);
      r_afull  <= (w_count_next >= L_AFULL);
      r_aempty <= (w_count_next <= L_AEMPTY);
      r_ovf    <= r_ovf | w_ovf_ev;
      r_udf    <= r_udf | w_udf_ev;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_rv_pipe[i] <= r_rv_pipe[i-1];
      end
      r_rv_pipe[0] <= w_ren;
    end
  end

  assign wenable   = w_wen;
  assign renable   = w_ren;
  assign waddr     = r_waddr;
  assign raddr     = r_raddr;
  assign rvalid    = r_rv_pipe[RD_LAT-1];
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;
  assign afull     = r_afull;
  assign aempty    = r_aempty;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: doc/ehgu_sync_fifo_ctrl.md
# ehgu_sync_fifo_ctrl

Single-clock FIFO controller that drives the address and enable pins of an external dual-port memory. It replaces the minimal pointer-only FIFO logic. It adds full, empty, almost-full and almost-empty flags, a level count, and sticky overflow and underflow errors. It also adds a synchronous flush, wrap-around for any depth (including non-power-of-two) and a configurable read-data-valid latency. It sits beside the memory macro in the ehgu datapath, and the memory itself is outside this block.

## Interface
- WIDTH, 8: data width of the attached memory; documentation only, no logic depends on it.
- DEPTH, 128: number of entries, at least 2; any integer is legal.
- AWIDTH, 8: address width; must satisfy 2**AWIDTH >= DEPTH.
- AFULL_TH, DEPTH-4: afull is asserted when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 4: aempty is asserted when count <= AEMPTY_TH; legal range 0..DEPTH-1.
- RD_LAT, 1: memory read latency in cycles; legal values 1 or 2.
- clk  input  1  sole clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  block enable; when low, push and pop are ignored.
- flush  input  1  synchronous clear of FIFO state.
- push  input  1  write request.
- pop  input  1  read request.
- wenable  output  1  memory write enable (combinational).
- waddr  output  AWIDTH  memory write address (registered write pointer).
- renable  output  1  memory read enable (combinational).
- raddr  output  AWIDTH  memory read address (registered read pointer).
- rvalid  output  1  memory read data is valid this cycle.
- count  output  AWIDTH+1  number of stored entries, 0..DEPTH.
- full, empty, afull, aempty  output  1 each  registered level flags.
- overflow, underflow  output  1 each  sticky error flags.

## Operation
- Accept rules:
  - wenable = en & push & !full & !flush.
  - renable = en & pop & !empty & !flush.
  - Full and empty are the registered flags, so there is no same-cycle bypass.
- Pointer update: a pointer increments on each accepted access. It wraps from DEPTH-1 to 0 by explicit compare; modulo on a non-power-of-two depth is not used.
- count_next:
  - +1 on write only.
  - -1 on read only.
  - unchanged when both or neither are accepted.
- Flags are registered from count_next:
  - full = (count_next == DEPTH)
  - empty = (count_next == 0)
  - afull = (count_next >= AFULL_TH)
  - aempty = (count_next <= AEMPTY_TH)
- Overflow and underflow:
  - overflow is set on en & push & full & !flush.
  - underflow is set on en & pop & empty & !flush.
  - Both stay set until flush or reset.
- Simultaneous push and pop:
  - When full, only the pop is accepted, and overflow is set.
  - When empty, only the push is accepted, and underflow is set.
  - Otherwise both are accepted and count is unchanged.
- flush has priority over push and pop in the same cycle. On the next edge it clears the pointers, count, overflow, underflow and the rvalid pipeline. Flags return to their reset values, and no error is raised.
- en low: state and flags are held and no errors are flagged. The rvalid pipeline keeps shifting, so reads already in flight still complete.
- Reset values:
  - waddr = 0, raddr = 0, count = 0.
  - empty = 1, aempty = 1, full = 0, afull = 0.
  - overflow = 0, underflow = 0, rvalid = 0.
  - wenable and renable are 0 while in reset.

## Timing
- wenable and renable are valid in the same cycle as the request. waddr and raddr present the slot address in that same cycle.
- count, the flags and the pointers update on the rising edge after an accepted access, giving 1-cycle latency.
- rvalid equals renable delayed by RD_LAT cycles through a shift register.
- Reset asserted mid-operation clears everything asynchronously. Any in-flight rvalid is dropped.
- Back-to-back push every cycle is sustained at 1 entry per cycle until full; pop behaves the same way.

## Test plan
Bench configuration: DEPTH=5, AWIDTH=3, AFULL_TH=4, AEMPTY_TH=1, RD_LAT=2.

- **Reset:** rstn low, then released with all inputs at 0 → count=0, empty=1, aempty=1, full=0, afull=0, overflow=0, underflow=0, rvalid=0, waddr=0, raddr=0.
- **Fill and overflow:** 6 consecutive pushes → waddr steps 0,1,2,3,4 then wraps to 0. afull rises after the 4th push and full after the 5th. The 6th push gives wenable=0 and overflow=1, with count held at 5.
- **Drain and underflow:** 6 pops starting from full → raddr steps 0..4 then wraps to 0. rvalid follows each renable 2 cycles later. empty rises after the 5th pop. The 6th pop gives renable=0 and underflow=1.
- **Simultaneous push and pop:**
  - At count=2: both enables are 1, count stays 2, and both pointers advance.
  - At full: only renable=1, count becomes 4, and overflow=1.
  - At empty: only wenable=1 and underflow=1.
- **Flush mid-stream:** at count=3 with push, pop and an rvalid in flight, assert flush → wenable=renable=0 that cycle. On the next edge, count=0, pointers=0, overflow=0, underflow=0, empty=1, and the pending rvalid is suppressed.
- **Enable low, then reset:** en=0 with push and pop asserted → state is held and no error flags are set, but a pending rvalid still fires. Asserting rstn low mid-fill restores every reset value immediately.
